// File: rtl/keypad_event_pkg.sv
// Shared definitions for the keypad event controller.
//   reg_addr_t  : register select decode for the 2-bit bus address
//   *_BIT       : bit positions of fields inside the EVENT/STATUS/CTRL words
//   key_event_t : one queued event, {level, idx}
package keypad_event_pkg;

    typedef enum logic [1:0] {
        ADDR_STATE  = 2'd0,
        ADDR_EVENT  = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_CTRL   = 2'd3
    } reg_addr_t;

    // EVENT word
    localparam int unsigned EVT_VALID_BIT = 31;
    localparam int unsigned EVT_LEVEL_BIT = 8;
    localparam int unsigned EVT_IDX_W     = 5;

    // STATUS word
    localparam int unsigned STS_OVF_BIT   = 7;
    localparam int unsigned STS_FULL_BIT  = 6;
    localparam int unsigned STS_COUNT_W   = 6;

    // CTRL word
    localparam int unsigned CTRL_IRQ_EN_BIT     = 0;
    localparam int unsigned CTRL_FLUSH_BIT      = 1;
    localparam int unsigned CTRL_PRESS_ONLY_BIT = 2;

    typedef struct packed {
        logic                 level;
        logic [EVT_IDX_W-1:0] idx;
    } key_event_t;

endpackage

// File: rtl/keypad_event_ctrl_key_debouncer.sv
// Per-key synchroniser and debouncer.
//   clk, reset    : clock, asynchronous active-high reset
//   i_key         : raw key level (asynchronous)
//   o_stable      : accepted (debounced) level
//   o_change      : one-cycle pulse in the cycle the stable level is about to flip
//   o_new_level   : level that o_change will load into o_stable
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_stable,
    output logic o_change,
    output logic o_new_level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_differ;

    assign w_differ    = (r_sync2 != r_stable);
    // The increment that would make the counter reach DEBOUNCE_CYCLES is the
    // one that accepts the new level instead.
    assign o_change    = w_differ && (r_cnt == CNT_LAST);
    assign o_stable    = r_stable;
    assign o_new_level = r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (o_change) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Memory-mapped keypad controller: debounces NUM_KEYS raw inputs, queues
// press/release events in a FIFO and exposes them on the data-memory bus.
//   clk, reset : fastClk, asynchronous active-high reset
//   keys_in    : raw key levels, 1 = pressed
//   en, addr   : bank select and register select (STATE/EVENT/STATUS/CTRL)
//   rd_pop     : read strobe that pops the EVENT FIFO head
//   memWrite   : byte enables (bit 0 only), wdata : write data
//   rdata      : combinational read data, 0 when not selected
//   irq        : registered level interrupt, irq_en & FIFO not empty
module keypad_event_ctrl
    import keypad_event_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    input  logic                en,
    input  logic [1:0]          addr,
    input  logic                rd_pop,
    input  logic [3:0]          memWrite,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [NUM_KEYS-1:0] w_stable;
    logic [NUM_KEYS-1:0] w_change;
    logic [NUM_KEYS-1:0] w_new_level;
    logic [NUM_KEYS-1:0] w_set;
    logic [NUM_KEYS-1:0] w_push_sel;
    logic [NUM_KEYS-1:0] r_pending;

    logic                w_any;
    key_event_t          w_push_event;

    key_event_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;
    logic                r_irq_en;
    logic                r_press_only;
    logic                r_irq;

    logic                w_empty;
    logic                w_full;
    logic                w_ctrl_wr;
    logic                w_flush;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    key_event_t          w_head;
    logic                w_unused_ok;

    assign w_unused_ok = ^{memWrite[3:1], wdata[31:3]};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .reset      (reset),
            .i_key      (keys_in[k]),
            .o_stable   (w_stable[k]),
            .o_change   (w_change[k]),
            .o_new_level(w_new_level[k])
        );
    end

    // In press-only mode a falling edge still updates the stable level but
    // never raises a pending flag.
    assign w_set = w_change & (w_new_level | {NUM_KEYS{~r_press_only}});

    // Lowest-index pending key wins; the event carries its current stable level.
    always_comb begin
        w_any        = 1'b0;
        w_push_sel   = '0;
        w_push_event = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (r_pending[k] && !w_any) begin
                w_any              = 1'b1;
                w_push_sel[k]      = 1'b1;
                w_push_event.level = w_stable[k];
                w_push_event.idx   = EVT_IDX_W'(k);
            end
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_ctrl_wr = en && memWrite[0] && (addr == ADDR_CTRL);
    assign w_flush   = w_ctrl_wr && wdata[CTRL_FLUSH_BIT];
    assign w_pop     = en && rd_pop && (addr == ADDR_EVENT) && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_any && (!w_full || w_pop);
    assign w_drop    = w_any && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];

    // The selected pending bit is consumed whether pushed or dropped; a
    // simultaneous new detection on that key keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_push_sel) | w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_event;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en     <= 1'b0;
            r_press_only <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en     <= wdata[CTRL_IRQ_EN_BIT];
                r_press_only <= wdata[CTRL_PRESS_ONLY_BIT];
            end
            r_irq <= r_irq_en && !w_empty;
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = '0;
        if (en) begin
            case (addr)
                ADDR_STATE: begin
                    rdata[NUM_KEYS-1:0] = w_stable;
                end
                ADDR_EVENT: begin
                    if (!w_empty) begin
                        rdata[EVT_VALID_BIT]       = 1'b1;
                        rdata[EVT_LEVEL_BIT]       = w_head.level;
                        rdata[EVT_IDX_W-1:0]       = w_head.idx;
                    end
                end
                ADDR_STATUS: begin
                    rdata[STS_OVF_BIT]         = r_overflow;
                    rdata[STS_FULL_BIT]        = w_full;
                    rdata[STS_COUNT_W-1:0]     = STS_COUNT_W'(r_count);
                end
                default: begin
                    rdata[CTRL_PRESS_ONLY_BIT] = r_press_only;
                    rdata[CTRL_IRQ_EN_BIT]     = r_irq_en;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
module tb_keypad_event_ctrl;

    localparam int NK = 8;
    localparam int D  = 16;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_in;
    logic          en;
    logic [1:0]    addr;
    logic          rd_pop;
    logic [3:0]    memWrite;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   exp_q[$];
    logic [NK-1:0] model_keys;
    logic [31:0]   d;

    always #5 clk = ~clk;

    keypad_event_ctrl #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .keys_in (keys_in),
        .en      (en),
        .addr    (addr),
        .rd_pop  (rd_pop),
        .memWrite(memWrite),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected EVENT word for a key reaching a new level.
    function automatic logic [31:0] ev(input int lvl, input int idx);
        return 32'h8000_0000 | (32'(lvl) << 8) | 32'(idx);
    endfunction

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        en = 1'b0; addr = 2'd0; rd_pop = 1'b0; memWrite = 4'h0; wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        en = 1'b1; addr = a; rd_pop = 1'b0; memWrite = 4'h0;
        #1;
        v = rdata;
        en = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        en = 1'b1; addr = 2'd3; rd_pop = 1'b0; memWrite = 4'h1; wdata = v;
        tick;
        bus_idle;
    endtask

    task automatic pop;
        en = 1'b1; addr = 2'd1; rd_pop = 1'b1; memWrite = 4'h0;
        tick;
        bus_idle;
    endtask

    // Pop until every expected event has been seen, bounded by maxc cycles.
    task automatic drain(input int maxc);
        int n = 0;
        while (n < maxc && exp_q.size() != 0) begin
            pop;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted pop of a valid event is compared with the scoreboard.
    task automatic monitor;
        forever begin
            @(negedge clk);
            if (en && rd_pop && addr == 2'd1 && rdata[31]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL event_unexpected: got %08h expected none", rdata);
                end else begin
                    check("event_pop", rdata, exp_q.pop_front());
                end
            end
        end
    endtask

    // Reference: a level held long enough produces one event per changed key,
    // in ascending index order; releases are suppressed in press-only mode.
    // Glitches shorter than D cycles produce nothing.
    task automatic random_run(input bit press_only, input int phases);
        bit stim_done = 1'b0;
        wr_ctrl(press_only ? 32'h4 : 32'h0);
        fork
            begin
                for (int p = 0; p < phases; p++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        logic [NK-1:0] mask;
                        mask = NK'($urandom_range(1, 255));
                        keys_in = model_keys ^ mask;
                        repeat ($urandom_range(1, D - 1)) tick;
                        keys_in = model_keys;
                        repeat (6) tick;
                    end else begin
                        logic [NK-1:0] nv;
                        nv = NK'($urandom_range(0, 255));
                        for (int k = 0; k < NK; k++) begin
                            if (nv[k] != model_keys[k] && !(press_only && !nv[k]))
                                exp_q.push_back(ev(int'(nv[k]), k));
                        end
                        model_keys = nv;
                        keys_in = nv;
                        repeat ($urandom_range(40, 60)) tick;
                    end
                end
                stim_done = 1'b1;
            end
            begin
                int n = 0;
                while ((!stim_done || exp_q.size() != 0) && n < 4000) begin
                    en = 1'b1; addr = 2'd1; memWrite = 4'h0;
                    rd_pop = ($urandom_range(0, 3) != 0);
                    tick;
                    n++;
                end
                bus_idle;
            end
        join
        check("rand_left", 32'(exp_q.size()), 32'd0);
        rd(2'd0, d); check("rand_state", d, 32'(model_keys));
        rd(2'd2, d); check("rand_status", d, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle;
        keys_in    = '0;
        model_keys = '0;
        reset      = 1'b1;
        fork
            monitor;
        join_none
        repeat (3) tick;
        rd(2'd0, d); check("reset_state", d, 32'h0);
        rd(2'd2, d); check("reset_status", d, 32'h0);
        rd(2'd3, d); check("reset_ctrl", d, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        tick;

        // Key 3 press: exact settle latency, count, event word
        keys_in[3] = 1'b1;
        repeat (D + 1) tick;
        rd(2'd0, d); check("t1_state_early", d, 32'h0);
        tick;
        rd(2'd0, d); check("t1_state", d, 32'h08);
        tick;
        rd(2'd2, d); check("t1_count", d, 32'h1);
        rd(2'd1, d); check("t1_event", d, 32'h8000_0103);
        exp_q.push_back(ev(1, 3));
        drain(10);
        keys_in[3] = 1'b0;
        exp_q.push_back(ev(0, 3));
        drain(100);

        // Glitch on key 5 is filtered
        keys_in[5] = 1'b1;
        repeat (10) tick;
        keys_in[5] = 1'b0;
        repeat (30) tick;
        rd(2'd0, d); check("t2_state", d, 32'h0);
        rd(2'd2, d); check("t2_status", d, 32'h0);

        // Simultaneous rises drain in index order
        keys_in = 8'b0101_0010;
        repeat (D + 6) tick;
        rd(2'd2, d); check("t3_count", d, 32'h3);
        exp_q.push_back(ev(1, 1));
        exp_q.push_back(ev(1, 4));
        exp_q.push_back(ev(1, 6));
        drain(10);
        rd(2'd1, d); check("t3_event_empty", d, 32'h0);
        keys_in = '0;
        exp_q.push_back(ev(0, 1));
        exp_q.push_back(ev(0, 4));
        exp_q.push_back(ev(0, 6));
        drain(100);

        // Overflow: 9 events into an 8-entry FIFO, then flush
        keys_in = 8'hFF;
        repeat (D + 12) tick;
        rd(2'd2, d); check("t4_full_no_ovf", d, 32'h48);
        keys_in[0] = 1'b0;
        repeat (D + 6) tick;
        rd(2'd2, d); check("t4_overflow", d, 32'hC8);
        rd(2'd1, d); check("t4_head", d, ev(1, 0));
        wr_ctrl(32'h2);
        rd(2'd2, d); check("t4_flush_status", d, 32'h0);
        rd(2'd3, d); check("t4_ctrl", d, 32'h0);

        // Full FIFO with coincident push and pop
        keys_in = 8'h01;
        repeat (D + 12) tick;
        rd(2'd2, d); check("t5_full", d, 32'h48);
        exp_q.push_back(ev(1, 0));
        for (int k = 1; k < NK; k++) exp_q.push_back(ev(0, k));
        keys_in[7] = 1'b1;
        repeat (D + 2) tick;
        en = 1'b1; addr = 2'd1; rd_pop = 1'b1;
        tick;
        bus_idle;
        rd(2'd2, d); check("t5_push_pop_full", d, 32'h48);
        exp_q.push_back(ev(1, 7));
        drain(50);
        rd(2'd2, d); check("t5_empty", d, 32'h0);
        en = 1'b1; addr = 2'd1; rd_pop = 1'b1;
        #1;
        check("t5_pop_empty_rdata", rdata, 32'h0);
        tick;
        bus_idle;
        rd(2'd2, d); check("t5_pop_empty_status", d, 32'h0);
        keys_in = '0;
        exp_q.push_back(ev(0, 0));
        exp_q.push_back(ev(0, 7));
        drain(100);

        // Press-only mode, irq, async reset mid-debounce
        wr_ctrl(32'h5);
        rd(2'd3, d); check("t6_ctrl", d, 32'h5);
        keys_in[0] = 1'b1;
        repeat (D + 2) tick;
        check("t6_irq_before", 32'(irq), 32'h0);
        tick;
        rd(2'd2, d); check("t6_count", d, 32'h1);
        rd(2'd1, d); check("t6_head", d, ev(1, 0));
        tick;
        check("t6_irq", 32'(irq), 32'h1);
        keys_in[0] = 1'b0;
        repeat (D + 8) tick;
        rd(2'd2, d); check("t6_release_filtered", d, 32'h1);
        keys_in[2] = 1'b1;
        repeat (10) tick;
        #2;
        reset = 1'b1;
        #1;
        check("t6_reset_irq", 32'(irq), 32'h0);
        rd(2'd2, d); check("t6_reset_status", d, 32'h0);
        rd(2'd0, d); check("t6_reset_state", d, 32'h0);
        tick;
        reset = 1'b0;
        repeat (D + 1) tick;
        rd(2'd0, d); check("t6_settle_early", d, 32'h0);
        tick;
        rd(2'd0, d); check("t6_settle", d, 32'h04);
        exp_q.push_back(ev(1, 2));
        drain(10);
        keys_in = '0;
        exp_q.push_back(ev(0, 2));
        drain(100);

        // Randomized phases against the reference model
        model_keys = '0;
        random_run(1'b0, 14);
        random_run(1'b1, 14);
        keys_in = '0;
        model_keys = '0;
        repeat (D + 4) tick;
        rd(2'd2, d); check("final_status", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
